rgb_fade_sequencer: RTL and testbench

Controller that sequences the RGB PWM datapath through a programmable list of colour keyframes. Holds an 8-entry RGB keyframe table. Ramps three 16-bit duty registers toward each keyframe at a programmable step per tick, holds each keyframe for a programmable number of ticks, then advances with wrap-around. Outputs feed the PWM comparators directly, replacing button-driven duty counters when sequencing is enabled.

---
 rtl/rgb_seq_pkg.sv | 32 +++
 rtl/rgb_fade_sequencer_tick_gen.sv | 29 ++
 rtl/rgb_fade_sequencer.sv | 146 ++++++++++++++
 tb/tb_rgb_fade_sequencer.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_seq_pkg.sv
// Shared types and helpers for the RGB keyframe fade sequencer.
// The ramp arithmetic lives here so other LED blocks step duties the same way.
package rgb_seq_pkg;

  localparam int DUTY_W_DEF = 16;
  localparam int HOLD_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RAMP = 2'd2,
    HOLD = 2'd3
  } seq_state_t;

  // A zero step is treated as 1 so a ramp can never stall; the move is clamped
  // to the remaining distance, so the result never crosses the target.
  function automatic logic [31:0] step_toward(input logic [31:0] cur,
                                              input logic [31:0] tgt,
                                              input logic [31:0] step);
    logic [31:0] stp;
    logic [31:0] diff;
    stp = (step == 32'd0) ? 32'd1 : step;
    if (cur < tgt) begin
      diff        = tgt - cur;
      step_toward = cur + ((stp < diff) ? stp : diff);
    end else begin
      diff        = cur - tgt;
      step_toward = cur - ((stp < diff) ? stp : diff);
    end
  endfunction

endpackage

// File: rtl/rgb_fade_sequencer_tick_gen.sv
// Free-running prescaler: one-cycle tick every TICK_DIV clocks while clr is low.
// clr holds the count at zero, so the first tick lands TICK_DIV cycles after clr drops.
module tick_gen #(
  parameter int TICK_DIV = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign tick = !clr && (r_cnt == LAST);

endmodule

// File: rtl/rgb_fade_sequencer.sv
// Steps three PWM duty registers through a programmable RGB keyframe table,
// ramping at a bounded rate per tick and holding each colour for a set number of ticks.
module rgb_fade_sequencer
  import rgb_seq_pkg::*;
#(
  parameter int DUTY_W   = DUTY_W_DEF,
  parameter int NUM_KEYS = 8,
  parameter int TICK_DIV = 1024,
  parameter int HOLD_W   = HOLD_W_DEF,
  localparam int AW      = $clog2(NUM_KEYS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                cfg_we,
  input  logic [AW-1:0]       cfg_addr,
  input  logic [3*DUTY_W-1:0] cfg_rgb,
  input  logic [HOLD_W-1:0]   cfg_hold,
  input  logic [AW:0]         num_keys,
  input  logic [DUTY_W-1:0]   step,
  output logic [DUTY_W-1:0]   r_duty,
  output logic [DUTY_W-1:0]   g_duty,
  output logic [DUTY_W-1:0]   b_duty,
  output logic                duty_upd,
  output logic [AW-1:0]       key_idx,
  output logic                busy
);

  localparam int KW = AW + 1;

  seq_state_t r_state, w_state_nxt;

  logic [3*DUTY_W-1:0] r_tbl_rgb  [NUM_KEYS];
  logic [HOLD_W-1:0]   r_tbl_hold [NUM_KEYS];

  logic [DUTY_W-1:0] r_duty_r, r_duty_g, r_duty_b;
  logic [DUTY_W-1:0] r_tgt_r, r_tgt_g, r_tgt_b;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [AW-1:0]     r_key_idx;
  logic              r_duty_upd;

  logic              w_tick, w_tick_clr, w_at_tgt, w_advance, w_ramp_step;
  logic [KW-1:0]     w_nk_eff, w_key_inc;
  logic [AW-1:0]     w_key_nxt;
  logic [3*DUTY_W-1:0] w_ld_rgb;
  logic [DUTY_W-1:0] w_nxt_r, w_nxt_g, w_nxt_b;

  // Prescaler restarts on every LOAD so each keyframe's ramp begins on a fresh period.
  assign w_tick_clr = (r_state == IDLE) || (r_state == LOAD);

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_tick_clr),
    .tick (w_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        r_tbl_rgb[i]  <= '0;
        r_tbl_hold[i] <= '0;
      end
    end else if (cfg_we) begin
      r_tbl_rgb[cfg_addr]  <= cfg_rgb;
      r_tbl_hold[cfg_addr] <= cfg_hold;
    end
  end

  assign w_nk_eff  = (num_keys == '0)              ? KW'(1) :
                     (num_keys > KW'(NUM_KEYS))    ? KW'(NUM_KEYS) : num_keys;
  assign w_key_inc = {1'b0, r_key_idx} + KW'(1);
  assign w_key_nxt = (w_key_inc >= w_nk_eff) ? '0 : w_key_inc[AW-1:0];

  assign w_at_tgt = (r_duty_r == r_tgt_r) && (r_duty_g == r_tgt_g) && (r_duty_b == r_tgt_b);

  always_comb begin
    w_state_nxt = r_state;
    w_advance   = 1'b0;
    case (r_state)
      IDLE: if (enable) w_state_nxt = LOAD;
      LOAD: w_state_nxt = RAMP;
      RAMP: if (w_at_tgt) w_state_nxt = HOLD;
      HOLD: begin
        // Zero hold advances on entry; otherwise the final tick both expires and advances.
        if ((r_hold_cnt == '0) || (w_tick && (r_hold_cnt == HOLD_W'(1)))) begin
          w_advance   = 1'b1;
          w_state_nxt = LOAD;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (!enable) begin
      w_state_nxt = IDLE;
      w_advance   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  assign w_ld_rgb    = r_tbl_rgb[r_key_idx];
  assign w_ramp_step = (r_state == RAMP) && w_tick && enable;

  assign w_nxt_r = w_ramp_step ? DUTY_W'(step_toward(32'(r_duty_r), 32'(r_tgt_r), 32'(step))) : r_duty_r;
  assign w_nxt_g = w_ramp_step ? DUTY_W'(step_toward(32'(r_duty_g), 32'(r_tgt_g), 32'(step))) : r_duty_g;
  assign w_nxt_b = w_ramp_step ? DUTY_W'(step_toward(32'(r_duty_b), 32'(r_tgt_b), 32'(step))) : r_duty_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_duty_r   <= '0;
      r_duty_g   <= '0;
      r_duty_b   <= '0;
      r_duty_upd <= 1'b0;
      r_tgt_r    <= '0;
      r_tgt_g    <= '0;
      r_tgt_b    <= '0;
      r_hold_cnt <= '0;
      r_key_idx  <= '0;
    end else begin
      r_duty_r   <= w_nxt_r;
      r_duty_g   <= w_nxt_g;
      r_duty_b   <= w_nxt_b;
      r_duty_upd <= (w_nxt_r != r_duty_r) || (w_nxt_g != r_duty_g) || (w_nxt_b != r_duty_b);
      if (r_state == LOAD) begin
        r_tgt_r    <= w_ld_rgb[3*DUTY_W-1 -: DUTY_W];
        r_tgt_g    <= w_ld_rgb[2*DUTY_W-1 -: DUTY_W];
        r_tgt_b    <= w_ld_rgb[DUTY_W-1 -: DUTY_W];
        r_hold_cnt <= r_tbl_hold[r_key_idx];
      end else if ((r_state == HOLD) && w_tick && (r_hold_cnt != '0)) begin
        r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
      end
      if (w_advance) r_key_idx <= w_key_nxt;
    end
  end

  assign r_duty   = r_duty_r;
  assign g_duty   = r_duty_g;
  assign b_duty   = r_duty_b;
  assign duty_upd = r_duty_upd;
  assign key_idx  = r_key_idx;
  assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Scoreboard bench for rgb_fade_sequencer with a 4-cycle tick.
module tb_rgb_fade_sequencer;

  localparam int DW = 16;
  localparam int NK = 8;
  localparam int TD = 4;
  localparam int HW = 8;
  localparam int AW = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            enable;
  logic            cfg_we;
  logic [AW-1:0]   cfg_addr;
  logic [3*DW-1:0] cfg_rgb;
  logic [HW-1:0]   cfg_hold;
  logic [AW:0]     num_keys;
  logic [DW-1:0]   step;
  logic [DW-1:0]   r_duty, g_duty, b_duty;
  logic            duty_upd;
  logic [AW-1:0]   key_idx;
  logic            busy;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [DW-1:0] r;
    logic [DW-1:0] g;
    logic [DW-1:0] b;
    int            cyc;
  } exp_t;

  exp_t exp_q[$];
  int   key_q[$];

  always #5 clk = ~clk;

  rgb_fade_sequencer #(
    .DUTY_W(DW), .NUM_KEYS(NK), .TICK_DIV(TD), .HOLD_W(HW)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_rgb(cfg_rgb), .cfg_hold(cfg_hold), .num_keys(num_keys), .step(step),
    .r_duty(r_duty), .g_duty(g_duty), .b_duty(b_duty), .duty_upd(duty_upd),
    .key_idx(key_idx), .busy(busy)
  );

  task automatic push_duty(input logic [DW-1:0] r, input logic [DW-1:0] g,
                           input logic [DW-1:0] b, input int cyc);
    exp_t e;
    e.r = r; e.g = g; e.b = b; e.cyc = cyc;
    exp_q.push_back(e);
  endtask

  task automatic write_key(input int a, input logic [DW-1:0] r, input logic [DW-1:0] g,
                           input logic [DW-1:0] b, input logic [HW-1:0] h);
    @(negedge clk);
    cfg_we   = 1'b1;
    cfg_addr = AW'(a);
    cfg_rgb  = {r, g, b};
    cfg_hold = h;
    @(negedge clk);
    cfg_we   = 1'b0;
  endtask

  task automatic do_reset();
    enable = 1'b0;
    cfg_we = 1'b0;
    rst    = 1'b1;
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    exp_q.delete();
    key_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_rgb = '0;
    cfg_hold = '0; num_keys = 4'd1; step = 16'd1;
    repeat (3) @(negedge clk);
    tests++;
    if ({r_duty, g_duty, b_duty} !== '0) begin
      fails++; $display("FAIL reset_duty: got %h/%h/%h want 0/0/0", r_duty, g_duty, b_duty);
    end
    tests++;
    if (busy !== 1'b0 || key_idx !== 3'd0 || duty_upd !== 1'b0) begin
      fails++; $display("FAIL reset_ctrl: busy=%b key=%0d upd=%b want 0/0/0", busy, key_idx, duty_upd);
    end
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      tests++;
      if (duty_upd !== 1'b0 || {r_duty, g_duty, b_duty} !== '0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL idle_quiet cyc %0d: upd=%b duty=%h/%h/%h busy=%b want 0", i, duty_upd, r_duty, g_duty, b_duty, busy);
      end
    end
  endtask

  task automatic test_single_ramp();
    exp_t e;
    do_reset();
    write_key(0, 16'h0010, 16'h0000, 16'h0008, 8'd2);
    num_keys = 4'd1;
    step     = 16'd4;
    enable   = 1'b1;
    push_duty(16'd4,  16'd0, 16'd4, 6);
    push_duty(16'd8,  16'd0, 16'd8, 10);
    push_duty(16'd12, 16'd0, 16'd8, 14);
    push_duty(16'd16, 16'd0, 16'd8, 18);
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (duty_upd === 1'b1) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++; $display("FAIL single_extra: upd at cyc %0d duty %h/%h/%h, none expected", c, r_duty, g_duty, b_duty);
        end else begin
          e = exp_q.pop_front();
          if ({r_duty, g_duty, b_duty} !== {e.r, e.g, e.b} || c != e.cyc) begin
            fails++;
            $display("FAIL single_ramp: got %h/%h/%h at cyc %0d want %h/%h/%h at cyc %0d", r_duty, g_duty, b_duty, c, e.r, e.g, e.b, e.cyc);
          end
        end
      end
    end
    tests++;
    if (exp_q.size() != 0 || key_idx !== 3'd0 || busy !== 1'b1) begin
      fails++; $display("FAIL single_end: pending=%0d key=%0d busy=%b want 0/0/1", exp_q.size(), key_idx, busy);
    end
    enable = 1'b0;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || {r_duty, g_duty, b_duty} !== {16'd16, 16'd0, 16'd8}) begin
      fails++; $display("FAIL single_disable: busy=%b duty=%h/%h/%h want 0 0010/0000/0008", busy, r_duty, g_duty, b_duty);
    end
  endtask

  task automatic test_clamp_down();
    exp_t e;
    logic [AW-1:0] last_key;
    int k;
    do_reset();
    write_key(0, 16'd6, 16'd6, 16'd6, 8'd0);
    write_key(1, 16'd0, 16'd0, 16'd0, 8'd0);
    num_keys = 4'd2;
    step     = 16'd4;
    enable   = 1'b1;
    last_key = 3'd0;
    push_duty(16'd4, 16'd4, 16'd4, -1);
    push_duty(16'd6, 16'd6, 16'd6, -1);
    push_duty(16'd2, 16'd2, 16'd2, -1);
    push_duty(16'd0, 16'd0, 16'd0, -1);
    key_q.push_back(1);
    key_q.push_back(0);
    for (int c = 1; c <= 300 && (exp_q.size() > 0 || key_q.size() > 0); c++) begin
      @(negedge clk);
      if (duty_upd === 1'b1) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++; $display("FAIL clamp_extra: duty %h/%h/%h, none expected", r_duty, g_duty, b_duty);
        end else begin
          e = exp_q.pop_front();
          if ({r_duty, g_duty, b_duty} !== {e.r, e.g, e.b}) begin
            fails++; $display("FAIL clamp_duty: got %h/%h/%h want %h/%h/%h", r_duty, g_duty, b_duty, e.r, e.g, e.b);
          end
        end
      end
      if (key_idx !== last_key) begin
        tests++;
        k = (key_q.size() > 0) ? key_q.pop_front() : -1;
        if (key_idx !== AW'(k) || k < 0) begin
          fails++; $display("FAIL clamp_key: got %0d want %0d", key_idx, k);
        end
        last_key = key_idx;
      end
    end
    tests++;
    if (exp_q.size() != 0 || key_q.size() != 0) begin
      fails++; $display("FAIL clamp_timeout: pending duty=%0d key=%0d want 0/0", exp_q.size(), key_q.size());
    end
    enable = 1'b0;
  endtask

  task automatic test_step0_nk0();
    exp_t e;
    do_reset();
    write_key(0, 16'd3, 16'd2, 16'd1, 8'd0);
    num_keys = 4'd0;
    step     = 16'd0;
    enable   = 1'b1;
    push_duty(16'd1, 16'd1, 16'd1, -1);
    push_duty(16'd2, 16'd2, 16'd1, -1);
    push_duty(16'd3, 16'd2, 16'd1, -1);
    for (int c = 1; c <= 120; c++) begin
      @(negedge clk);
      if (duty_upd === 1'b1) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++; $display("FAIL step0_extra: duty %h/%h/%h, none expected", r_duty, g_duty, b_duty);
        end else begin
          e = exp_q.pop_front();
          if ({r_duty, g_duty, b_duty} !== {e.r, e.g, e.b}) begin
            fails++; $display("FAIL step0_duty: got %h/%h/%h want %h/%h/%h", r_duty, g_duty, b_duty, e.r, e.g, e.b);
          end
        end
      end
      if (key_idx !== 3'd0) begin
        tests++; fails++; $display("FAIL step0_key: got %0d want 0", key_idx);
      end
    end
    tests++;
    if (exp_q.size() != 0 || busy !== 1'b1) begin
      fails++; $display("FAIL step0_end: pending=%0d busy=%b want 0/1", exp_q.size(), busy);
    end
    enable = 1'b0;
  endtask

  task automatic test_midrun_write_disable();
    exp_t e;
    logic [AW-1:0] last_key;
    int k;
    int n_pop;
    do_reset();
    write_key(0, 16'h0000, 16'h0000, 16'h0000, 8'd0);
    write_key(1, 16'h0040, 16'h0000, 16'h0000, 8'd0);
    num_keys = 4'd2;
    step     = 16'h0010;
    enable   = 1'b1;
    last_key = 3'd0;
    n_pop    = 0;
    push_duty(16'h10, 16'h00, 16'h00, -1);
    push_duty(16'h20, 16'h00, 16'h00, -1);
    push_duty(16'h30, 16'h00, 16'h00, -1);
    push_duty(16'h40, 16'h00, 16'h00, -1);
    push_duty(16'h30, 16'h00, 16'h00, -1);
    push_duty(16'h20, 16'h00, 16'h00, -1);
    push_duty(16'h10, 16'h00, 16'h00, -1);
    push_duty(16'h00, 16'h00, 16'h00, -1);
    push_duty(16'h00, 16'h10, 16'h00, -1);
    push_duty(16'h00, 16'h20, 16'h00, -1);
    key_q.push_back(1);
    key_q.push_back(0);
    key_q.push_back(1);
    for (int phase = 0; phase < 2; phase++) begin
      for (int c = 1; c <= 600 && (exp_q.size() > 0 || key_q.size() > 0); c++) begin
        @(negedge clk);
        cfg_we = 1'b0;
        if (duty_upd === 1'b1) begin
          tests++;
          if (exp_q.size() == 0) begin
            fails++; $display("FAIL mid_extra: duty %h/%h/%h, none expected", r_duty, g_duty, b_duty);
          end else begin
            e = exp_q.pop_front();
            n_pop++;
            if ({r_duty, g_duty, b_duty} !== {e.r, e.g, e.b}) begin
              fails++; $display("FAIL mid_duty #%0d: got %h/%h/%h want %h/%h/%h", n_pop, r_duty, g_duty, b_duty, e.r, e.g, e.b);
            end
            if (n_pop == 2) begin
              cfg_we   = 1'b1;
              cfg_addr = 3'd1;
              cfg_rgb  = {16'h0000, 16'h0030, 16'h0000};
              cfg_hold = 8'd0;
            end
          end
        end
        if (key_idx !== last_key) begin
          tests++;
          k = (key_q.size() > 0) ? key_q.pop_front() : -1;
          if (key_idx !== AW'(k) || k < 0) begin
            fails++; $display("FAIL mid_key: got %0d want %0d", key_idx, k);
          end
          last_key = key_idx;
        end
      end
      tests++;
      if (exp_q.size() != 0 || key_q.size() != 0) begin
        fails++; $display("FAIL mid_timeout phase %0d: pending duty=%0d key=%0d", phase, exp_q.size(), key_q.size());
      end
      if (phase == 0) begin
        enable = 1'b0;
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || key_idx !== 3'd1) begin
          fails++; $display("FAIL mid_idle: busy=%b key=%0d want 0/1", busy, key_idx);
        end
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          tests++;
          if (duty_upd !== 1'b0 || {r_duty, g_duty, b_duty} !== {16'h0, 16'h20, 16'h0}) begin
            fails++; $display("FAIL mid_frozen: upd=%b duty=%h/%h/%h want 0 0000/0020/0000", duty_upd, r_duty, g_duty, b_duty);
          end
        end
        enable = 1'b1;
        push_duty(16'h00, 16'h30, 16'h00, -1);
        key_q.push_back(0);
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_wrap();
    exp_t e;
    logic [AW-1:0] last_key;
    logic [DW-1:0] rv;
    int k;
    do_reset();
    for (int i = 0; i < NK; i++) begin
      rv = DW'((i + 1) * 16'h1111);
      write_key(i, rv, 16'hFFFF - rv, DW'(i * 16'h0100 + 5), 8'd0);
      push_duty(rv, 16'hFFFF - rv, DW'(i * 16'h0100 + 5), -1);
      key_q.push_back((i + 1) % NK);
    end
    num_keys = 4'd8;
    step     = 16'hFFFF;
    enable   = 1'b1;
    last_key = 3'd0;
    for (int c = 1; c <= 400 && (exp_q.size() > 0 || key_q.size() > 0); c++) begin
      @(negedge clk);
      if (duty_upd === 1'b1) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++; $display("FAIL wrap_extra: duty %h/%h/%h, none expected", r_duty, g_duty, b_duty);
        end else begin
          e = exp_q.pop_front();
          if ({r_duty, g_duty, b_duty} !== {e.r, e.g, e.b}) begin
            fails++; $display("FAIL wrap_duty: got %h/%h/%h want %h/%h/%h", r_duty, g_duty, b_duty, e.r, e.g, e.b);
          end
        end
      end
      if (key_idx !== last_key) begin
        tests++;
        k = (key_q.size() > 0) ? key_q.pop_front() : -1;
        if (key_idx !== AW'(k) || k < 0) begin
          fails++; $display("FAIL wrap_key: got %0d want %0d", key_idx, k);
        end
        last_key = key_idx;
      end
    end
    tests++;
    if (exp_q.size() != 0 || key_q.size() != 0) begin
      fails++; $display("FAIL wrap_timeout: pending duty=%0d key=%0d want 0/0", exp_q.size(), key_q.size());
    end
    enable = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    write_key(0, 16'h0100, 16'h0100, 16'h0100, 8'd0);
    num_keys = 4'd1;
    step     = 16'd1;
    enable   = 1'b1;
    repeat (30) @(negedge clk);
    tests++;
    if (r_duty !== 16'd7 || busy !== 1'b1) begin
      fails++; $display("FAIL arst_pre: r=%0d busy=%b want 7/1", r_duty, busy);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({r_duty, g_duty, b_duty} !== '0 || busy !== 1'b0 || key_idx !== 3'd0 || duty_upd !== 1'b0) begin
      fails++; $display("FAIL arst_now: duty=%h/%h/%h busy=%b key=%0d upd=%b want all 0", r_duty, g_duty, b_duty, busy, key_idx, duty_upd);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      tests++;
      if (duty_upd !== 1'b0 || {r_duty, g_duty, b_duty} !== '0) begin
        fails++; $display("FAIL arst_table: upd=%b duty=%h/%h/%h want 0 (cleared table)", duty_upd, r_duty, g_duty, b_duty);
      end
    end
    tests++;
    if (busy !== 1'b1) begin
      fails++; $display("FAIL arst_rerun: busy=%b want 1", busy);
    end
    enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_ramp();
    test_clamp_down();
    test_step0_nk0();
    test_midrun_write_disable();
    test_wrap();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
